// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage controller: size codes, FSM encoding
// and byte-lane helpers used for request formatting.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_BUSY = 1'b1;

    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // Size code 2'b11 behaves as a word everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return BE_BYTE0 << off;
            SZ_HALF: return off[1] ? BE_HALF_HI : BE_HALF_LO;
            default: return BE_WORD;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: return {4{wdata[7:0]}};
            SZ_HALF: return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load-data lane select and sign/zero extension (purely combinational).
module mem_load_ext
    import mem_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [31:0] lane;
    logic        sign;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        lane   = rdata_i >> {off_i, 3'b000};
        sign   = 1'b0;
        data_o = lane;
        case (size_i)
            SZ_BYTE: begin
                sign   = ~unsigned_i & lane[7];
                data_o = {{24{sign}}, lane[7:0]};
            end
            SZ_HALF: begin
                sign   = ~unsigned_i & lane[15];
                data_o = {{16{sign}}, lane[15:0]};
            end
            default: data_o = lane;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM-stage controller: issues data-memory requests, stalls upstream while BUSY
// and registers results for MEM/WB. Optional BUSY timeout via MEM_TIMEOUT_EN.
module mem_access
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_res,
    input  logic [31:0] ex_wdata,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [1:0]  ex_size,
    input  logic        ex_unsigned,
    input  logic [4:0]  ex_write_reg,
    input  logic        ex_mem_to_reg,
    input  logic        ex_reg_write,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    input  logic        dm_ready,
    input  logic [31:0] dm_rdata,
    output logic        mem_valid,
    output logic [31:0] mem_read_data,
    output logic [31:0] mem_alu_res,
    output logic [4:0]  mem_write_reg,
    output logic        mem_mem_to_reg,
    output logic        mem_reg_write,
    output logic        mem_stall,
    output logic        mem_misalign,
    output logic        mem_bus_err
);

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("mem_access: TIMEOUT_CYC must be at least 1");
    end

    state_t      state_q, state_d;
    logic        dm_req_q, dm_req_d, dm_we_q, dm_we_d;
    logic [31:0] dm_addr_q, dm_addr_d, dm_wdata_q, dm_wdata_d;
    logic [3:0]  dm_be_q, dm_be_d;
    logic [1:0]  off_q, off_d, size_q, size_d;
    logic        uns_q, uns_d, rd_q, rd_d, hold_rw_q, hold_rw_d;
    logic        valid_q, valid_d, reg_write_q, reg_write_d, misalign_q, misalign_d;
    logic [31:0] read_data_q, read_data_d, alu_res_q, alu_res_d;
    logic [4:0]  write_reg_q, write_reg_d;
    logic        mem_to_reg_q, mem_to_reg_d;
    logic [31:0] load_data;
    logic        timeout_hit;

    mem_load_ext u_load_ext (
        .off_i      (off_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .rdata_i    (dm_rdata),
        .data_o     (load_data)
    );

    always_comb begin
        state_d      = state_q;
        dm_req_d     = dm_req_q;
        dm_we_d      = dm_we_q;
        dm_addr_d    = dm_addr_q;
        dm_wdata_d   = dm_wdata_q;
        dm_be_d      = dm_be_q;
        off_d        = off_q;
        size_d       = size_q;
        uns_d        = uns_q;
        rd_d         = rd_q;
        hold_rw_d    = hold_rw_q;
        read_data_d  = read_data_q;
        alu_res_d    = alu_res_q;
        write_reg_d  = write_reg_q;
        mem_to_reg_d = mem_to_reg_q;
        valid_d      = 1'b0;
        reg_write_d  = 1'b0;
        misalign_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ex_valid) begin
                    alu_res_d    = ex_alu_res;
                    write_reg_d  = ex_write_reg;
                    mem_to_reg_d = ex_mem_to_reg;
                    read_data_d  = '0;
                    if (!(ex_mem_read || ex_mem_write)) begin
                        valid_d     = 1'b1;
                        reg_write_d = ex_reg_write;
                    end else if (is_misaligned(ex_size, ex_alu_res[1:0])) begin
                        valid_d    = 1'b1;
                        misalign_d = 1'b1;
                    end else begin
                        // A load/store combination is executed as a load.
                        dm_req_d   = 1'b1;
                        dm_we_d    = ex_mem_write & ~ex_mem_read;
                        dm_addr_d  = {ex_alu_res[31:2], 2'b00};
                        dm_be_d    = byte_enable(ex_size, ex_alu_res[1:0]);
                        dm_wdata_d = store_lanes(ex_size, ex_wdata);
                        off_d      = ex_alu_res[1:0];
                        size_d     = ex_size;
                        uns_d      = ex_unsigned;
                        rd_d       = ex_mem_read;
                        hold_rw_d  = ex_reg_write;
                        state_d    = ST_BUSY;
                    end
                end
            end
            default: begin
                if (dm_ready) begin
                    read_data_d = rd_q ? load_data : '0;
                    valid_d     = 1'b1;
                    reg_write_d = hold_rw_q;
                    dm_req_d    = 1'b0;
                    state_d     = ST_IDLE;
                end else if (timeout_hit) begin
                    read_data_d = '0;
                    valid_d     = 1'b1;
                    dm_req_d    = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            dm_req_q     <= 1'b0;
            dm_we_q      <= 1'b0;
            dm_addr_q    <= '0;
            dm_wdata_q   <= '0;
            dm_be_q      <= '0;
            off_q        <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            rd_q         <= 1'b0;
            hold_rw_q    <= 1'b0;
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            misalign_q   <= 1'b0;
            read_data_q  <= '0;
            alu_res_q    <= '0;
            write_reg_q  <= '0;
            mem_to_reg_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dm_req_q     <= dm_req_d;
            dm_we_q      <= dm_we_d;
            dm_addr_q    <= dm_addr_d;
            dm_wdata_q   <= dm_wdata_d;
            dm_be_q      <= dm_be_d;
            off_q        <= off_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            rd_q         <= rd_d;
            hold_rw_q    <= hold_rw_d;
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            misalign_q   <= misalign_d;
            read_data_q  <= read_data_d;
            alu_res_q    <= alu_res_d;
            write_reg_q  <= write_reg_d;
            mem_to_reg_q <= mem_to_reg_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             bus_err_q;

    // cnt_q counts completed BUSY cycles; the abort fires on the last allowed one.
    assign timeout_hit = (cnt_q == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= (state_q == ST_BUSY) ? cnt_q + 1'b1 : '0;
            bus_err_q <= (state_q == ST_BUSY) && !dm_ready && timeout_hit;
        end
    end

    assign mem_bus_err = bus_err_q;
`else
    assign timeout_hit = 1'b0;
    assign mem_bus_err = 1'b0;
`endif

    assign dm_req         = dm_req_q;
    assign dm_we          = dm_we_q;
    assign dm_addr        = dm_addr_q;
    assign dm_wdata       = dm_wdata_q;
    assign dm_be          = dm_be_q;
    assign mem_valid      = valid_q;
    assign mem_read_data  = read_data_q;
    assign mem_alu_res    = alu_res_q;
    assign mem_write_reg  = write_reg_q;
    assign mem_mem_to_reg = mem_to_reg_q;
    assign mem_reg_write  = reg_write_q;
    assign mem_misalign   = misalign_q;
    assign mem_stall      = (state_q == ST_BUSY);

endmodule
